// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq -- iterative binary-to-BCD converter (shift-add-3).
// One operand bit is consumed per clock through a single bank of DIGITS
// add-3 cells. Input and output use valid/ready handshakes. Results that
// need more than DIGITS decimal digits raise overflow, and bcd_out then
// holds the value modulo 10^DIGITS.
// Optional build macro: SIGNED_BCD_EN treats bin_in as two's complement,
// converts its magnitude and adds the sign_out port.
module bcd_converter_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SIGNED_BCD_EN
    ,
    output logic                  sign_out
`endif
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Per-digit add-3 correction. Each digit is adjusted independently and
    // no carry crosses a digit boundary.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = v[4*k +: 4] + 4'd3;
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic [BCD_W-1:0]   adj_s;
    logic [BIN_W-1:0]   load_s;
    logic               accept_s;

    assign accept_s = in_valid && (state_q == IDLE);
    assign adj_s    = add3_all(bcd_q);

`ifdef SIGNED_BCD_EN
    logic sign_q, sign_d;

    // Magnitude of the two's-complement operand; the most negative value
    // wraps to itself, which read as unsigned is 2^(BIN_W-1).
    always_comb begin
        if (bin_in[BIN_W-1]) begin
            load_s = ~bin_in + {{(BIN_W-1){1'b0}}, 1'b1};
        end else begin
            load_s = bin_in;
        end
    end
`else
    assign load_s = bin_in;
`endif

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            SHIFT:   in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Datapath next values: load on accept, one add-3/shift step per SHIFT cycle.
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef SIGNED_BCD_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shift_d = load_s;
                    bcd_d   = {BCD_W{1'b0}};
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = 1'b0;
`ifdef SIGNED_BCD_EN
                    sign_d  = bin_in[BIN_W-1];
`endif
                end else begin
                    shift_d = shift_q;
                end
            end
            SHIFT: begin
                shift_d = {shift_q[BIN_W-2:0], 1'b0};
                bcd_d   = {adj_s[BCD_W-2:0], shift_q[BIN_W-1]};
                ovf_d   = ovf_q | adj_s[BCD_W-1];
                cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE:    bcd_d = bcd_q;
            default: bcd_d = bcd_q;
        endcase
    end

    // Datapath registers; reset clears everything and aborts any conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= {BIN_W{1'b0}};
            bcd_q   <= {BCD_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
`ifdef SIGNED_BCD_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef SIGNED_BCD_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;
`ifdef SIGNED_BCD_EN
    assign sign_out = sign_q;
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Testbench for bcd_converter_seq: scoreboard of expected {sign, overflow, bcd}
// pushed on input handshake and compared on output handshake.
// Instances: A (8 bit, 3 digits), B (8 bit, 2 digits), and with SIGNED_BCD_EN
// also C (16 bit, 5 digits).
module tb_bcd_converter_seq;

`ifdef SIGNED_BCD_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0]  bin_a, bin_b;
    logic [15:0] bin_c;
    logic        iv_a, iv_b, iv_c, ir_a, ir_b, ir_c;
    logic        ov_a, ov_b, ov_c, or_a, or_b, or_c;
    logic        ovf_a, ovf_b, ovf_c, sgn_a, sgn_b, sgn_c;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [19:0] bcd_c;

    logic [21:0] sb_a[$];
    logic [21:0] sb_b[$];
    logic [21:0] sb_c[$];

    always #5 clk = ~clk;

    bcd_converter_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_a), .in_valid(iv_a), .in_ready(ir_a),
        .bcd_out(bcd_a), .overflow(ovf_a), .out_valid(ov_a), .out_ready(or_a)
`ifdef SIGNED_BCD_EN
        , .sign_out(sgn_a)
`endif
    );

    bcd_converter_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_b), .in_valid(iv_b), .in_ready(ir_b),
        .bcd_out(bcd_b), .overflow(ovf_b), .out_valid(ov_b), .out_ready(or_b)
`ifdef SIGNED_BCD_EN
        , .sign_out(sgn_b)
`endif
    );

`ifdef SIGNED_BCD_EN
    bcd_converter_seq #(.BIN_W(16), .DIGITS(5)) dut_c (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_c), .in_valid(iv_c), .in_ready(ir_c),
        .bcd_out(bcd_c), .overflow(ovf_c), .out_valid(ov_c), .out_ready(or_c),
        .sign_out(sgn_c)
    );
`else
    assign sgn_a = 1'b0;
    assign sgn_b = 1'b0;
    assign sgn_c = 1'b0;
    assign ir_c  = 1'b0;
    assign ov_c  = 1'b0;
    assign ovf_c = 1'b0;
    assign bcd_c = 20'h0;
`endif

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {sign, overflow, 20-bit BCD of magnitude mod 10^d}.
    function automatic logic [21:0] model(input logic [15:0] v, input int w, input int d);
        longint     mag;
        logic       s;
        logic [19:0] b;
        mag = 0;
        s   = 1'b0;
        b   = 20'h0;
        for (int i = 0; i < w; i++) begin
            if (v[i]) mag += (64'd1 << i);
        end
        if (SGN && v[w-1]) begin
            s   = 1'b1;
            mag = (64'd1 << w) - mag;
        end
        for (int k = 0; k < d; k++) begin
            b[4*k +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {s, (mag != 0), b};
    endfunction

    function automatic logic rdy(input int which);
        case (which)
            0:       return ir_a;
            1:       return ir_b;
            default: return ir_c;
        endcase
    endfunction

    // Drive one operand (waits for in_ready); optionally records the expectation.
    task automatic send(input int which, input logic [15:0] v, input bit push);
        int n;
        n = 0;
        while (!rdy(which) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rdy(which)) check_eq("send_timeout", 32'd0, 32'd1);
        case (which)
            0: begin bin_a = v[7:0]; iv_a = 1'b1; if (push) sb_a.push_back(model(v, 8, 3)); end
            1: begin bin_b = v[7:0]; iv_b = 1'b1; if (push) sb_b.push_back(model(v, 8, 2)); end
            default: begin bin_c = v; iv_c = 1'b1; if (push) sb_c.push_back(model(v, 16, 5)); end
        endcase
        @(posedge clk); #1;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    endtask

    // Wait (bounded) until every expectation of an instance has been consumed.
    task automatic drain(input int which);
        int n;
        int sz;
        n = 0;
        sz = (which == 0) ? sb_a.size() : (which == 1) ? sb_b.size() : sb_c.size();
        while (sz != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
            sz = (which == 0) ? sb_a.size() : (which == 1) ? sb_b.size() : sb_c.size();
        end
        check_eq("drain", 32'(sz), 32'd0);
    endtask

    // Output monitors: compare on each output handshake.
    always @(negedge clk) begin
        if (ov_a && or_a) begin
            if (sb_a.size() == 0) check_eq("a_unexpected", 32'd1, 32'd0);
            else check_eq("a_result", {10'd0, sgn_a, ovf_a, 8'h0, bcd_a}, {10'd0, sb_a.pop_front()});
        end
        if (ov_b && or_b) begin
            if (sb_b.size() == 0) check_eq("b_unexpected", 32'd1, 32'd0);
            else check_eq("b_result", {10'd0, sgn_b, ovf_b, 12'h0, bcd_b}, {10'd0, sb_b.pop_front()});
        end
        if (ov_c && or_c) begin
            if (sb_c.size() == 0) check_eq("c_unexpected", 32'd1, 32'd0);
            else check_eq("c_result", {10'd0, sgn_c, ovf_c, bcd_c}, {10'd0, sb_c.pop_front()});
        end
    end

    initial begin
        logic [21:0] e;
        rst_n = 1'b0;
        bin_a = 8'd0; bin_b = 8'd0; bin_c = 16'd0;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        or_a = 1'b1; or_b = 1'b1; or_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(ir_a), 32'd1);
        check_eq("rst_out_valid", 32'(ov_a), 32'd0);
        check_eq("rst_bcd", 32'(bcd_a), 32'd0);
        check_eq("rst_ovf", 32'(ovf_a), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: accept at edge N, out_valid only after edge N+8.
        send(0, 16'd255, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        check_eq("lat_early", 32'(ov_a), 32'd0);
        @(posedge clk); #1;
        check_eq("lat_valid", 32'(ov_a), 32'd1);
        @(posedge clk); #1;
        check_eq("lat_ready_back", 32'(ir_a), 32'd1);
        drain(0);

        // Values on default instance.
        send(0, 16'd0, 1'b1);   drain(0);
        send(0, 16'd9, 1'b1);   drain(0);
        send(0, 16'd100, 1'b1); drain(0);
        send(0, 16'd127, 1'b1); drain(0);
        for (int i = 0; i < 6; i++) begin
            send(0, 16'($urandom_range(0, 255)), 1'b1);
            drain(0);
        end

        // Undersized instance: overflow and modulo result.
        send(1, 16'd100, 1'b1); drain(1);
        send(1, 16'd99, 1'b1);  drain(1);
        send(1, 16'd123, 1'b1); drain(1);

        // Backpressure: hold DONE 20 cycles, outputs stable, extra input refused.
        or_a = 1'b0;
        send(0, 16'd123, 1'b1);
        e = model(16'd123, 8, 3);
        begin
            int n;
            n = 0;
            while (!ov_a && n < 50) begin @(posedge clk); #1; n++; end
        end
        check_eq("bp_valid", 32'(ov_a), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin bin_a = 8'd7; iv_a = 1'b1; end
            else iv_a = 1'b0;
            @(posedge clk); #1;
            check_eq("bp_bcd", 32'(bcd_a), 32'(e[11:0]));
            check_eq("bp_in_ready", 32'(ir_a), 32'd0);
            check_eq("bp_valid_hold", 32'(ov_a), 32'd1);
        end
        iv_a = 1'b0;
        or_a = 1'b1;
        drain(0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_no_extra", 32'(ov_a), 32'd0);

        // Reset mid-SHIFT aborts the conversion.
        send(0, 16'd200, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("mid_rst_in_ready", 32'(ir_a), 32'd1);
        check_eq("mid_rst_bcd", 32'(bcd_a), 32'd0);
        check_eq("mid_rst_valid", 32'(ov_a), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_eq("mid_rst_no_valid", 32'(ov_a), 32'd0);
        end
        send(0, 16'd42, 1'b1); drain(0);

`ifdef SIGNED_BCD_EN
        send(2, 16'hFF80, 1'b1); drain(2);
        send(2, 16'h8000, 1'b1); drain(2);
        send(2, 16'd12345, 1'b1); drain(2);
        send(2, 16'hFFFF, 1'b1); drain(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
